// File: rtl/csrng_cmd_arbiter.sv
// Round-robin arbiter sharing the CSRNG core command path, locking onto one requester per packet.
// Optional idle-beat abort while locked is compiled in with CSRNG_ARB_TIMEOUT_EN.
module csrng_cmd_arbiter #(
    parameter int NumApps       = 3,
    parameter int CmdFifoWidth  = 32,
    parameter int TimeoutCycles = 255,
    localparam int IdW          = $clog2(NumApps)
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            enable_i,
    input  logic [NumApps-1:0]              req_i,
    output logic [NumApps-1:0]              gnt_o,
    input  logic [NumApps-1:0]              sop_i,
    input  logic [NumApps-1:0]              mop_i,
    input  logic [NumApps-1:0]              eop_i,
    input  logic [NumApps*CmdFifoWidth-1:0] bus_i,
    input  logic                            core_rdy_i,
    output logic                            core_vld_o,
    output logic                            core_sop_o,
    output logic                            core_eop_o,
    output logic [CmdFifoWidth-1:0]         core_bus_o,
    output logic [IdW-1:0]                  core_id_o,
    output logic                            busy_o,
    output logic                            timeout_o,
    output logic                            proto_err_o,
    output logic                            sm_err_o
);

    // Pairwise Hamming distance 4; all-zero and every other code fall into Error.
    typedef enum logic [5:0] {
        StIdle  = 6'b011100,
        StGnt   = 6'b101010,
        StLock  = 6'b110001,
        StError = 6'b000111
    } state_e;

    logic [5:0]              state_q;
    state_e                  state_d;
    logic [IdW-1:0]          owner_q, owner_d;
    logic [IdW-1:0]          last_q, last_d;
    logic                    vld_q, vld_d, sop_q, sop_d, eop_q, eop_d;
    logic [CmdFifoWidth-1:0] bus_q, bus_d;
    logic                    timeout_q, timeout_d;
    logic                    proto_q;

    logic                    legal;
    logic [NumApps-1:0]      any_beat;
    logic [NumApps-1:0]      owner_mask;
    logic                    owner_beat;
    logic                    proto_set;
    logic                    win_found;
    logic [IdW-1:0]          winner;
    int                      idx;
    logic                    to_hit;

    assign legal      = (state_q == StIdle) || (state_q == StGnt) || (state_q == StLock);
    assign any_beat   = sop_i | mop_i | eop_i;
    assign owner_mask = NumApps'(1) << owner_q;
    assign owner_beat = any_beat[owner_q];
    assign proto_set  = (state_q == StLock) ? |(any_beat & ~owner_mask) : |any_beat;

    always_comb begin
        win_found = 1'b0;
        winner    = '0;
        idx       = 0;
        for (int off = 1; off <= NumApps; off++) begin
            idx = (int'(last_q) + off) % NumApps;
            if (!win_found && req_i[idx]) begin
                win_found = 1'b1;
                winner    = IdW'(idx);
            end
        end
    end

`ifdef CSRNG_ARB_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d  = cnt_q;
        to_hit = 1'b0;
        if (state_q == StGnt) begin
            cnt_d = '0;
        end else if (state_q == StLock) begin
            if (owner_beat) begin
                cnt_d = '0;
            end else begin
                cnt_d  = cnt_q + 8'd1;
                to_hit = (cnt_d == 8'(TimeoutCycles));
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
`else
    assign to_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_e'(state_q);
        owner_d   = owner_q;
        last_d    = last_q;
        vld_d     = 1'b0;
        sop_d     = 1'b0;
        eop_d     = 1'b0;
        bus_d     = '0;
        timeout_d = 1'b0;
        if (legal && !enable_i) begin
            state_d = StIdle;
            last_d  = IdW'(NumApps - 1);
        end else begin
            case (state_q)
                StIdle: begin
                    if (core_rdy_i && win_found) begin
                        state_d = StGnt;
                        owner_d = winner;
                        last_d  = winner;
                    end
                end
                StGnt:  state_d = StLock;
                StLock: begin
                    if (owner_beat) begin
                        vld_d = 1'b1;
                        sop_d = sop_i[owner_q];
                        eop_d = eop_i[owner_q];
                        bus_d = bus_i[int'(owner_q)*CmdFifoWidth +: CmdFifoWidth];
                        if (eop_i[owner_q]) state_d = StIdle;
                    end else if (to_hit) begin
                        timeout_d = 1'b1;
                        state_d   = StIdle;
                    end
                end
                StError: state_d = StError;
                default: state_d = StError;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            owner_q   <= '0;
            last_q    <= IdW'(NumApps - 1);
            vld_q     <= 1'b0;
            sop_q     <= 1'b0;
            eop_q     <= 1'b0;
            bus_q     <= '0;
            timeout_q <= 1'b0;
            proto_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            vld_q     <= vld_d;
            sop_q     <= sop_d;
            eop_q     <= eop_d;
            bus_q     <= bus_d;
            timeout_q <= timeout_d;
            proto_q   <= proto_q | proto_set;
        end
    end

    assign gnt_o       = (state_q == StGnt) ? owner_mask : '0;
    assign busy_o      = (state_q == StGnt) || (state_q == StLock);
    assign core_vld_o  = vld_q;
    assign core_sop_o  = sop_q;
    assign core_eop_o  = eop_q;
    assign core_bus_o  = bus_q;
    assign core_id_o   = owner_q;
    assign timeout_o   = timeout_q;
    assign proto_err_o = proto_q;
    assign sm_err_o    = !legal;

endmodule

// File: tb/tb_csrng_cmd_arbiter.sv
// Directed bench for csrng_cmd_arbiter: a packet-level model checked every cycle plus literal spot checks.
// Define CSRNG_ARB_TIMEOUT_EN to also exercise the locked-packet abort with a 16-cycle limit.
module tb_csrng_cmd_arbiter;
    localparam int N   = 3;
    localparam int W   = 32;
    localparam int IdW = 2;
`ifdef CSRNG_ARB_TIMEOUT_EN
    localparam int TO = 16;
    localparam bit TimeoutOn = 1'b1;
`else
    localparam int TO = 255;
    localparam bit TimeoutOn = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           en = 1'b0;
    logic [N-1:0]   req = '0, sop = '0, mop = '0, eop = '0;
    logic [N*W-1:0] bus = '0;
    logic           rdy = 1'b0;
    logic [N-1:0]   gnt;
    logic           vld, csop, ceop, busy, tmo, perr, smerr;
    logic [W-1:0]   cbus;
    logic [IdW-1:0] cid;

    int checks = 0;
    int failures = 0;
    logic inject = 1'b0;

    csrng_cmd_arbiter #(.NumApps(N), .CmdFifoWidth(W), .TimeoutCycles(TO)) dut (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .req_i(req), .gnt_o(gnt),
        .sop_i(sop), .mop_i(mop), .eop_i(eop), .bus_i(bus), .core_rdy_i(rdy),
        .core_vld_o(vld), .core_sop_o(csop), .core_eop_o(ceop), .core_bus_o(cbus),
        .core_id_o(cid), .busy_o(busy), .timeout_o(tmo), .proto_err_o(perr),
        .sm_err_o(smerr)
    );

    always #5 clk = ~clk;

    // Packet-level model: phase 0 idle, 1 granted, 2 locked onto m_owner.
    int           m_phase = 0, m_owner = 0, m_last = N - 1, m_cnt = 0;
    logic         m_vld = 0, m_sop = 0, m_eop = 0, m_proto = 0, m_to = 0, m_err = 0;
    logic [W-1:0] m_bus = '0;
    logic [N-1:0] act;
    int           pick;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_owner = 0; m_last = N - 1; m_cnt = 0;
            m_vld = 0; m_sop = 0; m_eop = 0; m_bus = '0;
            m_proto = 0; m_to = 0; m_err = 0;
        end else begin
            act = sop | mop | eop;
            for (int i = 0; i < N; i++)
                if (act[i] && !(m_phase == 2 && i == m_owner)) m_proto = 1;
            m_vld = 0; m_sop = 0; m_eop = 0; m_bus = '0; m_to = 0;
            if (inject) m_err = 1;
            if (m_err) begin
                m_phase = 0;
            end else if (!en) begin
                m_phase = 0;
                m_last  = N - 1;
            end else if (m_phase == 0) begin
                if (rdy && (req != '0)) begin
                    pick = -1;
                    for (int k = 1; k <= N; k++)
                        if (pick < 0 && req[(m_last + k) % N]) pick = (m_last + k) % N;
                    m_owner = pick;
                    m_last  = pick;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                m_phase = 2;
                m_cnt   = 0;
            end else if (act[m_owner]) begin
                m_vld = 1;
                m_sop = sop[m_owner];
                m_eop = eop[m_owner];
                m_bus = bus[m_owner*W +: W];
                m_cnt = 0;
                if (eop[m_owner]) m_phase = 0;
            end else begin
                m_cnt++;
                if (TimeoutOn && m_cnt == TO) begin
                    m_to    = 1;
                    m_phase = 0;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        logic [N-1:0] exp_gnt;
        exp_gnt = (!m_err && m_phase == 1) ? N'(1 << m_owner) : '0;
        checkOutput("gnt", 64'(gnt), 64'(exp_gnt));
        checkOutput("busy", 64'(busy), 64'(!m_err && (m_phase == 1 || m_phase == 2)));
        checkOutput("vld", 64'(vld), 64'(m_vld));
        checkOutput("proto_err", 64'(perr), 64'(m_proto));
        checkOutput("timeout", 64'(tmo), 64'(m_to));
        checkOutput("sm_err", 64'(smerr), 64'(m_err || inject));
        if (m_vld) begin
            checkOutput("core_sop", 64'(csop), 64'(m_sop));
            checkOutput("core_eop", 64'(ceop), 64'(m_eop));
            checkOutput("core_bus", 64'(cbus), 64'(m_bus));
            checkOutput("core_id", 64'(cid), 64'(m_owner));
        end
    end

    // Drive one cycle of inputs (idx < 0 means no beat), then step past the next rising edge.
    task automatic applyStimulus(input logic [N-1:0] r, input int idx,
                                 input logic s, input logic m, input logic e,
                                 input logic [W-1:0] d);
        req = r; sop = '0; mop = '0; eop = '0; bus = '0;
        if (idx >= 0) begin
            sop[idx] = s; mop[idx] = m; eop[idx] = e;
            bus[idx*W +: W] = d;
        end
        @(posedge clk);
        #1;
    endtask

    int n;

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_gnt", 64'(gnt), 64'h0);
        checkOutput("rst_vld", 64'(vld), 64'h0);
        checkOutput("rst_busy", 64'(busy), 64'h0);
        checkOutput("rst_id", 64'(cid), 64'h0);
        rst_n = 1'b1; en = 1'b1; rdy = 1'b1;

        // Simultaneous requests: 0, then 1, then 2, then 0 again.
        applyStimulus(3'b111, -1, 0, 0, 0, '0);
        checkOutput("gnt_first", 64'(gnt), 64'h1);
        applyStimulus(3'b110, -1, 0, 0, 0, '0);
        applyStimulus(3'b110, 0, 1, 0, 1, 32'h1111_0000);
        checkOutput("single_vld", 64'(vld), 64'h1);
        applyStimulus(3'b110, -1, 0, 0, 0, '0);
        checkOutput("gnt_second", 64'(gnt), 64'h2);
        applyStimulus(3'b100, -1, 0, 0, 0, '0);
        applyStimulus(3'b100, 1, 1, 0, 0, 32'h0000_2013);
        checkOutput("beat1_bus", 64'(cbus), 64'h0000_2013);
        checkOutput("beat1_sop", 64'(csop), 64'h1);
        checkOutput("beat1_id", 64'(cid), 64'h1);
        applyStimulus(3'b100, 1, 0, 1, 0, 32'hA5A5_A5A5);
        checkOutput("beat2_bus", 64'(cbus), 64'hA5A5_A5A5);
        applyStimulus(3'b100, 1, 0, 1, 1, 32'h5A5A_5A5A);
        checkOutput("beat3_eop", 64'(ceop), 64'h1);
        checkOutput("beat3_bus", 64'(cbus), 64'h5A5A_5A5A);
        checkOutput("beat3_idle", 64'(busy), 64'h0);
        applyStimulus(3'b100, -1, 0, 0, 0, '0);
        checkOutput("gnt_third", 64'(gnt), 64'h4);
        applyStimulus(3'b001, -1, 0, 0, 0, '0);
        applyStimulus(3'b001, 2, 1, 0, 1, 32'hCAFE_0002);
        applyStimulus(3'b001, -1, 0, 0, 0, '0);
        checkOutput("gnt_wrap", 64'(gnt), 64'h1);

        // Foreign beat from requester 2 while 0 owns the path.
        applyStimulus(3'b000, -1, 0, 0, 0, '0);
        applyStimulus(3'b000, 0, 1, 0, 0, 32'hAAAA_0001);
        applyStimulus(3'b000, 2, 0, 1, 0, 32'hDEAD_BEEF);
        checkOutput("foreign_perr", 64'(perr), 64'h1);
        checkOutput("foreign_vld", 64'(vld), 64'h0);
        applyStimulus(3'b000, 0, 0, 0, 1, 32'hAAAA_0002);
        checkOutput("owner_eop", 64'(ceop), 64'h1);
        checkOutput("owner_bus", 64'(cbus), 64'hAAAA_0002);

        // Disable mid-packet, then requester 0 wins again over 2.
        applyStimulus(3'b010, -1, 0, 0, 0, '0);
        checkOutput("gnt_pre_dis", 64'(gnt), 64'h2);
        applyStimulus(3'b000, -1, 0, 0, 0, '0);
        applyStimulus(3'b000, 1, 1, 0, 0, 32'h0101_0101);
        en = 1'b0;
        applyStimulus(3'b000, -1, 0, 0, 0, '0);
        checkOutput("dis_busy", 64'(busy), 64'h0);
        checkOutput("dis_vld", 64'(vld), 64'h0);
        en = 1'b1;
        applyStimulus(3'b111, -1, 0, 0, 0, '0);
        checkOutput("gnt_after_dis", 64'(gnt), 64'h1);
        applyStimulus(3'b000, -1, 0, 0, 0, '0);
        applyStimulus(3'b000, 0, 1, 0, 1, 32'h0000_0042);

        // Core not ready: request held, no grant.
        rdy = 1'b0;
        repeat (3) applyStimulus(3'b010, -1, 0, 0, 0, '0);
        checkOutput("nordy_gnt", 64'(gnt), 64'h0);
        rdy = 1'b1;
        applyStimulus(3'b010, -1, 0, 0, 0, '0);
        checkOutput("rdy_gnt", 64'(gnt), 64'h2);
        applyStimulus(3'b000, -1, 0, 0, 0, '0);
        applyStimulus(3'b000, 1, 1, 0, 1, 32'h0000_0077);

`ifdef CSRNG_ARB_TIMEOUT_EN
        applyStimulus(3'b100, -1, 0, 0, 0, '0);
        checkOutput("gnt_to", 64'(gnt), 64'h4);
        applyStimulus(3'b000, -1, 0, 0, 0, '0);
        applyStimulus(3'b000, 2, 1, 0, 0, 32'h0000_0099);
        n = 0;
        while (n < 40 && !tmo) begin
            applyStimulus(3'b000, -1, 0, 0, 0, '0);
            n++;
        end
        checkOutput("timeout_cycles", 64'(n), 64'd16);
        applyStimulus(3'b111, -1, 0, 0, 0, '0);
        checkOutput("gnt_after_to", 64'(gnt), 64'h1);
        applyStimulus(3'b000, -1, 0, 0, 0, '0);
        applyStimulus(3'b000, 0, 1, 0, 1, 32'h0000_00AA);
`endif

        // State register corruption must land in a sticky Error.
        applyStimulus(3'b000, -1, 0, 0, 0, '0);
        force dut.state_q = 6'b000000;
        inject = 1'b1;
        applyStimulus(3'b000, -1, 0, 0, 0, '0);
        release dut.state_q;
        applyStimulus(3'b000, -1, 0, 0, 0, '0);
        checkOutput("err_sticky", 64'(smerr), 64'h1);
        en = 1'b0;
        repeat (2) applyStimulus(3'b000, -1, 0, 0, 0, '0);
        en = 1'b1;
        applyStimulus(3'b111, -1, 0, 0, 0, '0);
        applyStimulus(3'b111, -1, 0, 0, 0, '0);
        checkOutput("err_toggle", 64'(smerr), 64'h1);
        checkOutput("err_no_gnt", 64'(gnt), 64'h0);
        inject = 1'b0;
        rst_n = 1'b0;
        req = '0;
        #1;
        checkOutput("err_cleared", 64'(smerr), 64'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        applyStimulus(3'b000, -1, 0, 0, 0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end
endmodule

// File: doc/csrng_cmd_arbiter.md
# csrng_cmd_arbiter

Round-robin arbiter that shares the single CSRNG core command path between `NumApps` command-stage instances (SW register interface plus hardware application interfaces). It grants one requester at a time and locks onto that requester for a whole command packet, from SOP through EOP. It forwards each beat through one register stage to the core, tagged with the requester index. A sparse-encoded FSM with a sticky error state provides fault detection.

## Interface
Parameters:
- `NumApps`, 3, number of requesters (2..8).
- `CmdFifoWidth`, 32, command beat width.
- `TimeoutCycles`, 255, idle-beat limit while locked. Used only when the timeout feature is compiled in. Legal range 1..255.

Ports (`IdW = $clog2(NumApps)`):
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `enable_i`  in  1  module enable; low forces a clean return to Idle.
- `req_i`  in  NumApps  arbitration request per requester.
- `gnt_o`  out  NumApps  one-hot, single-cycle grant.
- `sop_i`, `mop_i`, `eop_i`  in  NumApps each  per-requester beat qualifiers.
- `bus_i`  in  NumApps*CmdFifoWidth  per-requester beat data; requester i occupies slice [i*CmdFifoWidth +: CmdFifoWidth].
- `core_rdy_i`  in  1  core can accept a new packet. Sampled only at arbitration.
- `core_vld_o`  out  1  registered beat valid.
- `core_sop_o`, `core_eop_o`  out  1  registered packet delimiters.
- `core_bus_o`  out  CmdFifoWidth  registered beat data.
- `core_id_o`  out  IdW  index of the current owner.
- `busy_o`  out  1  high in Gnt or Lock.
- `timeout_o`  out  1  single-cycle pulse when a locked packet is aborted.
- `proto_err_o`  out  1  sticky protocol error.
- `sm_err_o`  out  1  FSM error.

## Operation
- **FSM states:** Idle, Gnt, Lock, Error. Encoding is 6 bits with pairwise Hamming distance ≥3. Any unlisted encoding goes to Error.
- **Error state:** Error is terminal until reset and asserts `sm_err_o`.
- **Idle:** if `enable_i`, `core_rdy_i` and `|req_i`, select a winner and go to Gnt.
  - The winner is the first requesting index strictly after `last_q`, searching modulo `NumApps`.
  - Store the winner in `owner_q` and load `last_q <= winner`.
- **Gnt:** `gnt_o[owner_q]=1` for exactly one cycle, then go to Lock.
- **Lock:** each cycle, register `sop_i[owner_q]|mop_i[owner_q]|eop_i[owner_q]` into `core_vld_o`, along with the matching sop/eop qualifiers and `bus_i` slice.
  - A beat with `eop_i[owner_q]` returns the FSM to Idle in the same clock that registers the beat.
  - SOP and EOP may be asserted together (a single-beat command).
  - Gaps between beats are permitted.
- **`core_id_o`:** equals `owner_q` whenever `core_vld_o` is high.
- **Protocol errors:** `proto_err_o` is set, and stays set until reset, when either of these occurs:
  - any sop/mop/eop from a requester other than the owner, or
  - any sop/mop/eop at all while not in Lock.
  - The offending beat is dropped and not forwarded.
- **Disable:** `enable_i` low in any legal state gives next state Idle.
  - Beat outputs are cleared and `last_q` is set to `NumApps-1`.
  - A packet in flight is discarded; no EOP is emitted.
- **Priority:** `enable_i` low has priority over beat handling. Beat handling has priority over timeout.

## Timing
- **Reset values:** all outputs 0; `last_q = NumApps-1`, so requester 0 wins first; `owner_q = 0`; state Idle.
- **Grant latency:** 1 cycle. `req_i` seen in Idle at cycle N gives `gnt_o` at N+1 and Lock at N+2.
- **Beat latency:** 1 cycle. A beat at cycle N appears on `core_*` at N+1.
- **Back-to-back packets:** EOP at N puts the FSM in Idle at N+1 and the next grant at N+2. Minimum packet-to-packet spacing is 3 cycles.
- **Requester obligation:** each requester drops `req_i` the cycle after its grant. A `req_i` still high in Idle is treated as a new request.
- **Simultaneous requests:** requests in the same cycle are resolved strictly round-robin. No requester waits more than `NumApps-1` packets.
- **`core_rdy_i` low in Idle:** the arbiter stays in Idle; `req_i` is held with no grant issued.

## Configuration
- **Macro:** `CSRNG_ARB_TIMEOUT_EN`.
- **Defined:**
  - An 8-bit counter clears on Gnt→Lock and on every owner beat, and increments each Lock cycle without a beat.
  - When the count reaches `TimeoutCycles`, the arbiter pulses `timeout_o` for one cycle and goes to Idle. `last_q` is kept, so the next requester gains priority.
  - No EOP is emitted for the aborted packet.
- **Undefined:** there is no counter, `timeout_o` is tied 0, and Lock waits indefinitely for EOP.

## Test plan
- **Reset and simultaneous request:** reset, then `req_i=3'b111` with `core_rdy_i=1` → `gnt_o=001` at N+1. After EOP, the next grants are 010, then 100, then 001.
- **Three-beat packet:** owner 1 sends SOP with bus=0x0000_2013, MOP=0xA5A5_A5A5, then MOP+EOP=0x5A5A_5A5A → `core_vld_o` is high for 3 cycles, each one cycle delayed, with `core_id_o=1`, `core_sop_o` on beat 1 and `core_eop_o` on beat 3. The FSM is back in Idle after the EOP.
- **Foreign beat:** requester 2 asserts `mop_i` while requester 0 owns the path → `proto_err_o=1` (sticky), no extra `core_vld_o`, and the owner's packet completes normally.
- **Disable mid-packet:** `enable_i` low after SOP → Idle the next cycle, `core_vld_o=0`, `busy_o=0`, and the next grant after re-enable goes to requester 0.
- **Timeout:** with `CSRNG_ARB_TIMEOUT_EN` defined and `TimeoutCycles=16`, the owner sends SOP and then goes silent → `timeout_o` pulses after 16 beat-free Lock cycles, and the next grant goes to the next requester.
- **Fault injection:** force the state register to 6'b000000 → `sm_err_o=1` and Error persists across `enable_i` toggling until `rst_ni` is asserted.
